// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, data-memory
// wait freezes with a timeout FSM, plus saturating stall/flush counters.
module hazard_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_write,
  output logic             IDEX_flush,
  output logic             EXMEM_write,
  output logic             MEMWB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic load_use;
  logic mem_freeze;
  logic stall_evt;
  logic flush_evt;

  assign load_use   = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                      ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
  assign mem_freeze = (dmem_req && !dmem_ready) || (state_q == ST_HALT);
  // A branch squashes the ID instruction, so its load-use is not a stall.
  assign stall_evt  = mem_freeze || (load_use && !EX_branch_taken);
  assign flush_evt  = !mem_freeze && EX_branch_taken;

  always_comb begin
    PC_write     = 1'b0;
    IFID_write   = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_write   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_write  = 1'b0;
    MEMWB_bubble = 1'b0;
    if (!rst_n) begin
      PC_write = 1'b0;
    end else if (mem_freeze) begin
      MEMWB_bubble = 1'b1;
    end else if (EX_branch_taken) begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IFID_flush  = 1'b1;
      IDEX_write  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_write = 1'b1;
    end else if (load_use) begin
      IDEX_flush  = 1'b1;
      IDEX_write  = 1'b1;
      EXMEM_write = 1'b1;
    end else begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IDEX_write  = 1'b1;
      EXMEM_write = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped request is treated like completion.
        if (dmem_ready || !dmem_req) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if ((TIMEOUT != 0) && (wait_cnt_q >= TIMEOUT_V)) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end else begin
      stall_d = stall_q;
    end
    if (flush_evt && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + 1'b1;
    end else begin
      flush_d = flush_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (TIMEOUT=4, CNT_W=4) driven by
// directed vectors with hand-computed expectations.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic       IDEX_MemRead, EX_branch_taken, dmem_req, dmem_ready;
  logic       PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush;
  logic       EXMEM_write, MEMWB_bubble, mem_timeout;
  logic [3:0] stall_cycles, flush_count;

  hazard_control_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .IDEX_rd(IDEX_rd),
    .IDEX_MemRead(IDEX_MemRead), .EX_branch_taken(EX_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .IDEX_write(IDEX_write), .IDEX_flush(IDEX_flush), .EXMEM_write(EXMEM_write),
    .MEMWB_bubble(MEMWB_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write, MEMWB_bubble}
  localparam logic [6:0] C_OFF  = 7'b0000000;
  localparam logic [6:0] C_NORM = 7'b1101010;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0001110;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic       to;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr, input logic br,
                      input logic req, input logic rdy, input logic [6:0] ec,
                      input logic eto, input int es, input int ef, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r; IFID_rs1 = rs1; IFID_rs2 = rs2; IDEX_rd = rd;
    IDEX_MemRead = mr; EX_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    e.name = nm; e.ctrl = ec; e.to = eto; e.stall = 4'(es); e.flush = 4'(ef);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are settled 2 time units after each input change.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush,
               EXMEM_write, MEMWB_bubble};
        n_checks += 4;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
        end
        if (mem_timeout !== e.to) begin
          n_fail++;
          $display("FAIL %s mem_timeout: got %b expected %b", e.name, mem_timeout, e.to);
        end
        if (stall_cycles !== e.stall) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.stall);
        end
        if (flush_count !== e.flush) begin
          n_fail++;
          $display("FAIL %s flush_count: got %0d expected %0d", e.name, flush_count, e.flush);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IDEX_rd = 5'd0;
    IDEX_MemRead = 1'b0; EX_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

    //   rst  rs1    rs2    rd     mr    br    req   rdy   ctrl    to    st  fl
    step(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_OFF,  1'b0, 0, 0, "reset");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 0, 0, "idle");
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 0, 0, "loaduse");
    step(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1, 0, "after_lu");
    step(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1, 0, "rd_zero");
    step(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   1'b0, 1, 0, "br_over_lu");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 1, 1, "after_br");
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 1 + i, 1, "wait_br");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, C_BR,   1'b0, 4, 1, "ready_br");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 4, 2, "after_wait");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 1'b0, 4, 2, "zero_wait");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  1'b0, 4, 2, "wait_one");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 5, 2, "req_drop");
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 5 + i, 2, "to_wait");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_FRZ,  1'b1, 10, 2, "halt_a");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, C_FRZ,  1'b1, 11, 2, "halt_b");
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_OFF,  1'b0, 0, 0, "rst_halt");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 0, 0, "post_rst");
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'd7, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, (i > 15) ? 15 : i, 0, "lu_sat");
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0, 15, 0, "sat_hold");

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the five-stage core; companion to the EX-stage forwarding logic.
- Detects load-use hazards, taken-branch flushes and data-memory wait states.
- Drives per-stage write-enable and flush controls.
- Tracks memory-wait time with a timeout FSM and keeps saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering HALT; 0 disables the timeout.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- IFID_rs1  input  5  rs1 of instruction in ID
- IFID_rs2  input  5  rs2 of instruction in ID
- IDEX_rd  input  5  rd of instruction in EX
- IDEX_MemRead  input  1  EX instruction is a load
- EX_branch_taken  input  1  branch/jump resolved taken in EX
- dmem_req  input  1  MEM stage is accessing data memory
- dmem_ready  input  1  data memory completes the access this cycle
- PC_write  output  1  PC update enable
- IFID_write  output  1  IF/ID register enable
- IFID_flush  output  1  load NOP into IF/ID
- IDEX_write  output  1  ID/EX register enable
- IDEX_flush  output  1  load bubble into ID/EX
- EXMEM_write  output  1  EX/MEM register enable
- MEMWB_bubble  output  1  load bubble (WriteBack=0) into MEM/WB
- mem_timeout  output  1  sticky timeout flag
- stall_cycles  output  CNT_W  stall-cycle counter
- flush_count  output  CNT_W  branch-flush event counter

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, both counters=0. While rst_n is low, all enables and flushes are 0.
- Internal signals:
  - load_use = IDEX_MemRead && IDEX_rd!=0 && (IDEX_rd==IFID_rs1 || IDEX_rd==IFID_rs2).
  - mem_freeze = dmem_req && !dmem_ready, or state==HALT.
- Controls are combinational from state and inputs, zero latency, and follow a fixed priority:
  - mem_freeze: PC_write=IFID_write=IDEX_write=EXMEM_write=0; MEMWB_bubble=1; no flushes. A pending branch or load-use is deferred; the held EX stage keeps presenting it.
  - Else EX_branch_taken: all writes=1, IFID_flush=1, IDEX_flush=1. A load-use in the same cycle is ignored because the ID instruction is squashed.
  - Else load_use: PC_write=0, IFID_write=0, IDEX_flush=1; IDEX_write=1, EXMEM_write=1; MEMWB_bubble=0.
  - Else: all writes=1, all flush/bubble=0.
- FSM states RUN, MEM_WAIT, HALT:
  - RUN -> MEM_WAIT when dmem_req && !dmem_ready; wait_cnt<=1.
  - MEM_WAIT -> RUN when dmem_ready; wait_cnt<=0.
  - MEM_WAIT stays MEM_WAIT when !dmem_ready and (TIMEOUT==0 or wait_cnt<TIMEOUT); wait_cnt<=wait_cnt+1, saturating.
  - MEM_WAIT -> HALT when !dmem_ready && TIMEOUT!=0 && wait_cnt==TIMEOUT; mem_timeout<=1.
  - HALT is terminal until rst_n; mem_timeout is sticky.
  - dmem_ready with dmem_req in the same cycle in RUN is a zero-wait access: no freeze, no state change.
  - dmem_req deasserting in MEM_WAIT is a protocol error; treat it as ready and return to RUN.
- Counters, registered, saturating at 2^CNT_W-1 with no wrap:
  - stall_cycles +1 on each cycle with mem_freeze or a load-use stall; HALT cycles count.
  - flush_count +1 on each cycle whose flush was actually applied (branch not deferred).
- Reset mid-wait aborts immediately to RUN with counters cleared.

Test Plan:
- lw x5 in EX (IDEX_MemRead=1, IDEX_rd=5), IFID_rs2=5 -> PC_write=0, IFID_write=0, IDEX_flush=1 for exactly 1 cycle; stall_cycles=1.
- IDEX_rd=0, IDEX_MemRead=1, IFID_rs1=0 -> no stall; all writes=1.
- EX_branch_taken=1 with load_use=1 -> IFID_flush=IDEX_flush=1, PC_write=1; flush_count=1, stall_cycles=0.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1, with EX_branch_taken held high throughout -> 3 freeze cycles (MEMWB_bubble=1); flush applied on the ready cycle; stall_cycles=3, flush_count=1; state back to RUN.
- TIMEOUT=4, dmem_ready held 0 -> HALT entered after 5 freeze cycles; mem_timeout=1; all writes stay 0 thereafter. Assert rst_n=0 mid-HALT -> mem_timeout=0 and counters=0 immediately.
- CNT_W=4, 20 load-use stalls -> stall_cycles saturates at 15.
